// File: rtl/hazard_stall_unit_if.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit_if
// Purpose : bundles the decode / execute / memory hazard fields and the stall
//           controls exchanged between the pipeline and hazard_stall_unit.
// Modports:
//   master - pipeline side: drives the hazard fields and receives the controls
//   slave  - hazard unit side: samples the hazard fields and drives the controls
// Signals :
//   RS1__IF_ID, RS2__IF_ID         source registers of the decode instruction
//   use_rs1_IF_ID, use_rs2_IF_ID   decode instruction actually reads rs1 / rs2
//   RD__ID_EX, WB__ID_EX           destination / write-back of the EX instruction
//   mem_2_reg_ID_EX, is_mult_ID_EX EX instruction is a load / a multiply
//   RD__EX_MEM, WB__EX_MEM         destination / write-back of the MEM instruction
//   mem_2_reg_EX_MEM               MEM instruction is a load
//   pc_write, if_id_write, id_ex_write       pipeline register write enables
//   id_ex_bubble, ex_mem_bubble              NOP insertion controls
//   mult_busy                                multiply stall active this cycle
// ----------------------------------------------------------------------------
interface hazard_stall_unit_if;
    logic [4:0] RS1__IF_ID;
    logic [4:0] RS2__IF_ID;
    logic       use_rs1_IF_ID;
    logic       use_rs2_IF_ID;
    logic [4:0] RD__ID_EX;
    logic       WB__ID_EX;
    logic       mem_2_reg_ID_EX;
    logic       is_mult_ID_EX;
    logic [4:0] RD__EX_MEM;
    logic       WB__EX_MEM;
    logic       mem_2_reg_EX_MEM;
    logic       pc_write;
    logic       if_id_write;
    logic       id_ex_write;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
    logic       mult_busy;

    modport master (
        output RS1__IF_ID, RS2__IF_ID, use_rs1_IF_ID, use_rs2_IF_ID,
        output RD__ID_EX, WB__ID_EX, mem_2_reg_ID_EX, is_mult_ID_EX,
        output RD__EX_MEM, WB__EX_MEM, mem_2_reg_EX_MEM,
        input  pc_write, if_id_write, id_ex_write,
        input  id_ex_bubble, ex_mem_bubble, mult_busy
    );

    modport slave (
        input  RS1__IF_ID, RS2__IF_ID, use_rs1_IF_ID, use_rs2_IF_ID,
        input  RD__ID_EX, WB__ID_EX, mem_2_reg_ID_EX, is_mult_ID_EX,
        input  RD__EX_MEM, WB__EX_MEM, mem_2_reg_EX_MEM,
        output pc_write, if_id_write, id_ex_write,
        output id_ex_bubble, ex_mem_bubble, mult_busy
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// ----------------------------------------------------------------------------
// hazard_stall_unit
// Purpose : stall / bubble controller for the 5-stage core. Resolves load-use
//           hazards that forwarding cannot cover (loads are never forwarded
//           out of EX/MEM) and freezes the front end while a multi-cycle
//           multiply occupies EX.
// Ports   :
//   clk  - core clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - hazard_stall_unit_if.slave: hazard fields in, stall controls out
//   stall_cycles (only with HAZARD_STALL_CNT_EN) - 32-bit count of cycles
//                  with pc_write=0, wraps, cleared by rst
// Parameters:
//   MULT_LATENCY - cycles a multiply occupies EX (1..16)
//   CNT_W        - multiply countdown width, 2^CNT_W >= MULT_LATENCY
// Optional feature macro: HAZARD_STALL_CNT_EN
// ----------------------------------------------------------------------------
module hazard_stall_unit #(
    parameter int MULT_LATENCY = 4,
    parameter int CNT_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef HAZARD_STALL_CNT_EN
    output logic [31:0]          stall_cycles,
`endif
    hazard_stall_unit_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // BUSY lasts MULT_LATENCY-2 cycles; the trigger cycle in IDLE is the
    // first stalled cycle and DONE is the final, unstalled cycle in EX.
    localparam int              CNT_LOAD_I = (MULT_LATENCY > 2) ? (MULT_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(CNT_LOAD_I);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic hz_ex;
    logic hz_mem;
    logic load_stall;
    logic mult_trig;
    logic mult_stall;

    // ------------------------------------------------------------------
    // Hazard detection (x0 is excluded since it is never really written)
    // ------------------------------------------------------------------
    always_comb begin
        hz_ex = bus.mem_2_reg_ID_EX && bus.WB__ID_EX && (bus.RD__ID_EX != 5'd0) &&
                ((bus.use_rs1_IF_ID && (bus.RS1__IF_ID == bus.RD__ID_EX)) ||
                 (bus.use_rs2_IF_ID && (bus.RS2__IF_ID == bus.RD__ID_EX)));
        hz_mem = bus.mem_2_reg_EX_MEM && bus.WB__EX_MEM && (bus.RD__EX_MEM != 5'd0) &&
                 ((bus.use_rs1_IF_ID && (bus.RS1__IF_ID == bus.RD__EX_MEM)) ||
                  (bus.use_rs2_IF_ID && (bus.RS2__IF_ID == bus.RD__EX_MEM)));
        load_stall = hz_ex || hz_mem;
    end

    // ------------------------------------------------------------------
    // Multiply FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mult_trig = (state_q == IDLE) && bus.is_mult_ID_EX && (MULT_LATENCY > 1);
        case (state_q)
            IDLE: begin
                if (mult_trig) begin
                    if (MULT_LATENCY > 2) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUSY: begin
                // cnt_q counts the BUSY cycles still to go, this one included
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                // The same multiply is leaving EX; its is_mult is not a new one
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        mult_stall = mult_trig || (state_q == BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Stall controls: multiply stall outranks the load-use stall
    // ------------------------------------------------------------------
    always_comb begin
        bus.pc_write      = 1'b1;
        bus.if_id_write   = 1'b1;
        bus.id_ex_write   = 1'b1;
        bus.id_ex_bubble  = 1'b0;
        bus.ex_mem_bubble = 1'b0;
        bus.mult_busy     = 1'b0;
        if (!rst) begin
            if (mult_stall) begin
                bus.pc_write      = 1'b0;
                bus.if_id_write   = 1'b0;
                bus.id_ex_write   = 1'b0;
                bus.ex_mem_bubble = 1'b1;
                bus.mult_busy     = 1'b1;
            end else if (load_stall) begin
                bus.pc_write      = 1'b0;
                bus.if_id_write   = 1'b0;
                bus.id_ex_bubble  = 1'b1;
            end
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (!bus.pc_write) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
